tx_arbiter: RTL and testbench
=============================

# tx_arbiter

Round-robin arbiter and sequencer that shares the single 55-bit serial transmitter between `N_REQ` packet sources in the router. It selects one pending requester, latches that requester's packet onto the transmitter's parallel data input, and issues a one-cycle start pulse. It then waits for the transmitter's ready pulse and returns a one-cycle grant/acknowledge to the selected source. A watchdog frees the transmitter if ready never arrives.

## Interface
- `N_REQ`, default 4: number of requesters; 2..8.
- `ID_W`, default 2: width of requester index; must be ≥ ceil(log2(`N_REQ`)).
- `DATA_W`, default 55: packet width; matches the transmitter's parallel input.
- `TIMEOUT`, default 100: maximum WAIT_RDY cycles before abort; 1..255.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  `N_REQ`  per-source request level.
- `req_data`  in  `N_REQ*DATA_W`  packets; source i occupies bits [i*DATA_W +: DATA_W].
- `tx_data`  out  `DATA_W`  registered packet to the transmitter.
- `tx_start`  out  1  registered one-cycle start pulse to the transmitter.
- `tx_ready`  in  1  one-cycle completion pulse from the transmitter.
- `gnt`  out  `N_REQ`  registered one-hot, one-cycle acknowledge.
- `gnt_id`  out  `ID_W`  index of the current or last selected source.
- `busy`  out  1  high whenever state ≠ IDLE.
- `timeout_err`  out  1  one-cycle pulse, coincident with `gnt`, when a transfer is aborted by the watchdog.

## Operation
- States: IDLE, START, WAIT_RDY, ACK. All outputs are registered.
- IDLE: if any `req` bit is set, select the first set bit searching from `(last+1) mod N_REQ` upward with wrap. On that clock edge:
  - latch the selected slice into `tx_data`;
  - load `gnt_id`;
  - clear the watchdog counter;
  - go to START.
- If no `req` bit is set, stay in IDLE.
- START: `tx_start`=1 for exactly this one cycle; go to WAIT_RDY.
- WAIT_RDY: the 8-bit counter increments each cycle.
  - If `tx_ready`=1, go to ACK.
  - Else if counter == `TIMEOUT`-1, go to ACK and set the abort flag.
  - If `tx_ready` and the timeout coincide in the same cycle, treat it as success: no `timeout_err`.
- ACK: `gnt[gnt_id]`=1 for one cycle, and `timeout_err`=abort flag. Update `last`←`gnt_id`, then go to IDLE.
- `tx_data` holds its value from the latch edge until the next latch. The transmitter reads it bit-serially throughout transmission.
- `req` dropping after the latch does not cancel the transfer; the grant is still issued. Sources hold `req` and data until `gnt`, then deassert or present the next packet.
- `tx_ready` seen in IDLE, START or ACK is ignored.
- `last` resets to `N_REQ`-1, so source 0 has initial priority. Sources with index ≥ `N_REQ` do not exist; ID values above `N_REQ`-1 never occur.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - state=IDLE;
  - `tx_start`=0, `gnt`=0, `timeout_err`=0, `busy`=0;
  - `tx_data`=0, `gnt_id`=0, counter=0, `last`=`N_REQ`-1.
- A reset mid-transfer aborts without a grant. Sources re-request after release.
- Let the `req` sample edge be the end of cycle 0:
  - cycle 1: START, `tx_start`=1, `tx_data` valid;
  - cycle 2 onward: WAIT_RDY.
- With the companion transmitter (6-bit start sequence plus 55 data bits), `tx_ready` arrives in cycle 64, `gnt` in cycle 65, and IDLE in cycle 66.
- Back-to-back requests: the next `tx_start` is in cycle 67, a 66-cycle packet period.
- `busy` rises in cycle 1 and falls in the cycle after ACK.
- A timeout with no `tx_ready` at all gives `gnt` and `timeout_err` in cycle 2+`TIMEOUT`.

## Test plan
- Reset, then `req`=4'b0001 with data 55'h12_3456_789A_BCDE and a transmitter model returning `tx_ready` 63 cycles after start. Expect:
  - `tx_start` high only in cycle 1;
  - `tx_data`=that value from cycle 1 onward;
  - `gnt`=4'b0001 in cycle 65;
  - `timeout_err`=0.
- `req`=4'b0101 held continuously. Expect grants in order 0, 2, 0, 2, with `tx_start` pulses 66 cycles apart.
- `req`=4'b1111 held. Expect grant order 0, 1, 2, 3, 0, and `gnt_id` matching each grant.
- Transmitter model never pulses ready, `TIMEOUT`=100. Expect `gnt`=4'b0001 and `timeout_err`=1 in cycle 102, then IDLE; the next request is served normally.
- `tx_ready` injected in IDLE and during START. Expect no state change. A `tx_ready` coinciding with the final timeout cycle produces `gnt` with `timeout_err`=0.
- Assert `rst`=0 during WAIT_RDY. Expect `busy`, `tx_start`, `gnt` and `tx_data` to go to 0 immediately, with no grant. After release, source 0 again has priority.

Source files
------------

// File: rtl/tx_arbiter.sv
// Round-robin arbiter that shares one serial transmitter between N_REQ packet sources.
// It latches the winner's packet, pulses start, waits for ready (or a watchdog), then acknowledges the source.
module tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 55,
  parameter int TIMEOUT = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_start,
  input  logic                    tx_ready,
  output logic [N_REQ-1:0]        gnt,
  output logic [ID_W-1:0]         gnt_id,
  output logic                    busy,
  output logic                    timeout_err
);

  typedef enum logic [1:0] {IDLE, START, WAIT_RDY, ACK} state_t;

  localparam logic [7:0]      LP_LAST_CNT  = 8'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] LP_LAST_INIT = ID_W'(N_REQ - 1);

  state_t              r_state;
  state_t              w_nextState;
  logic [7:0]          r_count;
  logic [ID_W-1:0]     r_last;
  logic [DATA_W-1:0]   r_txData;
  logic                r_txStart;
  logic [N_REQ-1:0]    r_gnt;
  logic [ID_W-1:0]     r_gntId;
  logic                r_busy;
  logic                r_timeoutErr;

  logic                w_found;
  logic [ID_W-1:0]     w_selId;
  logic [DATA_W-1:0]   w_selData;
  logic                w_timeoutHit;

  // Distance from the source after the last winner decides priority; the smallest distance wins.
  always_comb begin
    int bestOff;
    int off;
    w_found   = 1'b0;
    w_selId   = '0;
    w_selData = '0;
    bestOff   = N_REQ;
    off       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      off = (i + N_REQ - 1 - int'(r_last)) % N_REQ;
      if (req[i] && (off < bestOff)) begin
        bestOff   = off;
        w_found   = 1'b1;
        w_selId   = ID_W'(i);
        w_selData = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_timeoutHit = (r_count == LP_LAST_CNT);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (w_found) w_nextState = START;
      START:    w_nextState = WAIT_RDY;
      WAIT_RDY: if (tx_ready || w_timeoutHit) w_nextState = ACK;
      ACK:      w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_last       <= LP_LAST_INIT;
      r_txData     <= '0;
      r_txStart    <= 1'b0;
      r_gnt        <= '0;
      r_gntId      <= '0;
      r_busy       <= 1'b0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_txStart    <= (w_nextState == START);
      r_busy       <= (w_nextState != IDLE);
      r_gnt        <= '0;
      r_timeoutErr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_txData <= w_selData;
            r_gntId  <= w_selId;
            r_count  <= '0;
          end
        end
        WAIT_RDY: begin
          r_count <= r_count + 8'd1;
          if (w_nextState == ACK) begin
            r_gnt        <= N_REQ'(1) << r_gntId;
            r_timeoutErr <= !tx_ready;
          end
        end
        ACK:     r_last <= r_gntId;
        default: ;
      endcase
    end
  end

  assign tx_data     = r_txData;
  assign tx_start    = r_txStart;
  assign gnt         = r_gnt;
  assign gnt_id      = r_gntId;
  assign busy        = r_busy;
  assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: fixed vector table, hand-written corner sequences,
// and randomized transfers checked against a round-robin/latency model.
module tb_tx_arbiter;

  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int DATA_W  = 55;
  localparam int TIMEOUT = 100;
  localparam int NVEC    = 14;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [N_REQ-1:0]        req = '0;
  logic [N_REQ*DATA_W-1:0] req_data = '0;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_start;
  logic                    tx_ready;
  logic [N_REQ-1:0]        gnt;
  logic [ID_W-1:0]         gnt_id;
  logic                    busy;
  logic                    timeout_err;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   readyDelay = 0;
  int   modelCnt = 0;
  logic modelPulse = 1'b0;
  logic injectReady = 1'b0;

  int   refLast = N_REQ - 1;
  bit   prevValid = 1'b0;
  int   prevStartCyc = 0;
  int   prevExpLat = 0;

  typedef struct {
    bit              doReset;
    logic [N_REQ-1:0] reqVec;
    int              delay;
    int              expId;
    bit              expErr;
  } vec_t;

  vec_t tbl[NVEC];

  assign tx_ready = modelPulse | injectReady;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  tx_arbiter #(
    .N_REQ(N_REQ), .ID_W(ID_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout_err(timeout_err)
  );

  // Transmitter model: ready pulses 'readyDelay' cycles after the start cycle; 0 means never.
  always @(negedge clk) begin
    modelPulse = 1'b0;
    if (!rst) begin
      modelCnt = 0;
    end else begin
      if (modelCnt > 0) begin
        modelCnt--;
        if (modelCnt == 0) modelPulse = 1'b1;
      end
      if (tx_start && readyDelay > 0) modelCnt = readyDelay;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] reqVec, input logic [N_REQ*DATA_W-1:0] dataVec,
                               input int delay);
    req        = reqVec;
    req_data   = dataVec;
    readyDelay = delay;
  endtask

  function automatic int rrPick(input logic [N_REQ-1:0] r, input int last);
    for (int off = 1; off <= N_REQ; off++) begin
      if (r[(last + off) % N_REQ]) return (last + off) % N_REQ;
    end
    return -1;
  endfunction

  function automatic logic [N_REQ*DATA_W-1:0] mkData(input int e);
    logic [N_REQ*DATA_W-1:0] v;
    for (int i = 0; i < N_REQ; i++)
      v[i*DATA_W +: DATA_W] = DATA_W'(64'h0123_4567_89AB_CDEF * 64'(e*N_REQ + i + 1));
    if (e == 0) v[DATA_W-1:0] = 55'h12_3456_789A_BCDE;
    return v;
  endfunction

  task automatic resetPulse();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    #1;
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.tx_start", tx_start, 0);
    checkOutput("reset.gnt", gnt, 0);
    checkOutput("reset.timeout_err", timeout_err, 0);
    checkOutput("reset.tx_data", tx_data, 0);
    checkOutput("reset.gnt_id", gnt_id, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    refLast = N_REQ - 1;
    prevValid = 1'b0;
  endtask

  // One full transfer starting at a negedge while the arbiter is idle.
  task automatic runTransfer(input string tag, input logic [N_REQ-1:0] reqVec,
                             input logic [N_REQ*DATA_W-1:0] dataVec, input int delay,
                             input int expId, input bit expErr, input bit injectAtStart);
    int   waited;
    int   lat;
    int   expLat;
    int   startCyc;
    bit   seen;
    bit   extraStart;
    logic [DATA_W-1:0] expData;
    expData = dataVec[expId*DATA_W +: DATA_W];
    expLat  = (delay >= 1 && delay <= TIMEOUT) ? delay + 1 : TIMEOUT + 1;
    applyStimulus(reqVec, dataVec, delay);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 4) begin
      @(negedge clk);
      waited++;
      if (tx_start) seen = 1'b1;
    end
    checkOutput({tag, ".startLatency"}, seen ? waited : 99, 1);
    startCyc = cyc;
    if (prevValid) checkOutput({tag, ".startPeriod"}, startCyc - prevStartCyc, prevExpLat + 2);
    checkOutput({tag, ".tx_data"}, tx_data, expData);
    checkOutput({tag, ".gnt_id@start"}, gnt_id, expId);
    checkOutput({tag, ".busy@start"}, busy, 1);
    if (injectAtStart) injectReady = 1'b1;
    seen = 1'b0;
    extraStart = 1'b0;
    lat = 0;
    while (!seen && lat < TIMEOUT + 10) begin
      @(negedge clk);
      injectReady = 1'b0;
      lat++;
      if (tx_start) extraStart = 1'b1;
      if (gnt != '0) seen = 1'b1;
    end
    checkOutput({tag, ".gntLatency"}, seen ? lat : 9999, expLat);
    checkOutput({tag, ".singleStart"}, extraStart, 0);
    checkOutput({tag, ".gnt"}, gnt, N_REQ'(1) << expId);
    checkOutput({tag, ".timeout_err"}, timeout_err, expErr);
    checkOutput({tag, ".tx_dataHeld"}, tx_data, expData);
    refLast      = expId;
    prevValid    = 1'b1;
    prevStartCyc = startCyc;
    prevExpLat   = expLat;
    @(negedge clk);
    checkOutput({tag, ".idleBusy"}, busy, 0);
    checkOutput({tag, ".idleGnt"}, gnt, 0);
    checkOutput({tag, ".idleErr"}, timeout_err, 0);
  endtask

  initial begin
    logic [N_REQ*DATA_W-1:0] dv;
    logic [N_REQ-1:0] r;
    int d;
    int sel;

    tbl[0]  = '{1'b1, 4'b0001, 63, 0, 1'b0};
    tbl[1]  = '{1'b1, 4'b0101, 63, 0, 1'b0};
    tbl[2]  = '{1'b0, 4'b0101, 63, 2, 1'b0};
    tbl[3]  = '{1'b0, 4'b0101, 63, 0, 1'b0};
    tbl[4]  = '{1'b0, 4'b0101, 63, 2, 1'b0};
    tbl[5]  = '{1'b1, 4'b1111, 63, 0, 1'b0};
    tbl[6]  = '{1'b0, 4'b1111, 63, 1, 1'b0};
    tbl[7]  = '{1'b0, 4'b1111, 63, 2, 1'b0};
    tbl[8]  = '{1'b0, 4'b1111, 63, 3, 1'b0};
    tbl[9]  = '{1'b0, 4'b1111, 63, 0, 1'b0};
    tbl[10] = '{1'b1, 4'b0001, 0,  0, 1'b1};
    tbl[11] = '{1'b0, 4'b0001, 63, 0, 1'b0};
    tbl[12] = '{1'b0, 4'b0010, TIMEOUT, 1, 1'b0};
    tbl[13] = '{1'b0, 4'b1000, TIMEOUT + 1, 3, 1'b1};

    for (int e = 0; e < NVEC; e++) begin
      if (tbl[e].doReset) resetPulse();
      runTransfer($sformatf("vec%0d", e), tbl[e].reqVec, mkData(e), tbl[e].delay,
                  tbl[e].expId, tbl[e].expErr, 1'b0);
    end

    // Ready in IDLE must be ignored; ready during START must not end the wait early.
    resetPulse();
    applyStimulus('0, '0, 0);
    @(negedge clk);
    injectReady = 1'b1;
    @(negedge clk);
    injectReady = 1'b0;
    checkOutput("idleReady.busy", busy, 0);
    checkOutput("idleReady.tx_start", tx_start, 0);
    @(negedge clk);
    checkOutput("idleReady.busyLater", busy, 0);
    checkOutput("idleReady.gnt", gnt, 0);
    prevValid = 1'b0;
    runTransfer("startReady", 4'b1000, mkData(20), 0, 3, 1'b1, 1'b1);

    // Reset in the middle of WAIT_RDY aborts silently; source 0 regains priority afterwards.
    resetPulse();
    dv = mkData(21);
    runTransfer("preReset", 4'b1111, dv, 63, 0, 1'b0, 1'b0);
    applyStimulus(4'b1111, dv, 63);
    @(negedge clk);
    checkOutput("midReset.start", tx_start, 1);
    checkOutput("midReset.id", gnt_id, 1);
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midReset.busy", busy, 0);
    checkOutput("midReset.tx_start", tx_start, 0);
    checkOutput("midReset.gnt", gnt, 0);
    checkOutput("midReset.tx_data", tx_data, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("midReset.noGnt", gnt, 0);
    end
    rst = 1'b1;
    refLast = N_REQ - 1;
    prevValid = 1'b0;
    runTransfer("postReset", 4'b1111, dv, 63, 0, 1'b0, 1'b0);

    // Randomized transfers against the round-robin and latency rules.
    for (int t = 0; t < 25; t++) begin
      r = N_REQ'($urandom_range(1, 15));
      for (int i = 0; i < N_REQ; i++) dv[i*DATA_W +: DATA_W] = DATA_W'({$urandom, $urandom});
      case ($urandom_range(0, 9))
        0:       d = 0;
        1:       d = TIMEOUT;
        2:       d = TIMEOUT + 1 + int'($urandom_range(0, 5));
        default: d = int'($urandom_range(1, 80));
      endcase
      sel = rrPick(r, refLast);
      runTransfer($sformatf("rand%0d", t), r, dv, d, sel, (d == 0 || d > TIMEOUT), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
